cpu_clk_gen: RTL and testbench
==============================

# cpu_clk_gen

Parametrised clock-enable generator for the machine core: one free-running `clk_sys` domain producing CPU phase strobes, a reference bus strobe pair and an auxiliary (PSG) strobe. Supports two CPU timing modes, native ASIC timing and an alternate fixed-rate timing, with glitch-free hand-over between them and per-cycle contention stalls. Sits between the top-level mode/contention logic and the T80pa `CEN_p`/`CEN_n` inputs, replacing ad-hoc divider logic in the top level.

## Interface
Parameters:
- `DIV_NATIVE`, 16: `clk_sys` cycles per native CPU clock; even, ≥4.
- `DIV_ALT`, 27: `clk_sys` cycles per alternate CPU clock; ≥4.
- `DIV_AUX`, 12: `clk_sys` cycles per `ce_aux` pulse; ≥2.
- `GAP_PERIODS`, 3: idle alternate periods inserted on every mode switch; 1..15.

Ports:
- `clk_sys` in 1: system clock; every flop is clocked on it.
- `reset` in 1: asynchronous, active-high.
- `mode_alt` in 1: requests alternate timing (1) or native timing (0); level, may change at any time.
- `wait_req` in 1: contention request; stretches native CPU cycles.
- `throttle_off` in 1: when 1, `wait_req` is ignored.
- `ce_ref_p` out 1: native-rate positive-phase strobe; never gated.
- `ce_ref_n` out 1: native-rate negative-phase strobe; never gated.
- `ce_cpu_p` out 1: CPU positive-phase enable.
- `ce_cpu_n` out 1: CPU negative-phase enable.
- `ce_aux` out 1: auxiliary strobe, one per `DIV_AUX` cycles.
- `alt_active` out 1: 1 while the FSM is in ALT.
- `switching` out 1: 1 while the FSM is in DRAIN or GAP.

## Operation
- `cnt_n` counts 0..DIV_NATIVE-1 and wraps. `cnt_a` counts 0..DIV_ALT-1 and wraps. `cnt_x` counts 0..DIV_AUX-1 and wraps. All three run freely regardless of FSM state.
- Native phases: `pn_p` = (cnt_n==0), `pn_n` = (cnt_n==DIV_NATIVE/2).
- Alternate phases: `pa_p` = (cnt_a==0), `pa_n` = (cnt_a==DIV_ALT/2), truncated division.
- `en` register: when cnt_n==0, `en` <= ~wait_req | throttle_off | (state==ALT). Otherwise `en` holds its value.
- FSM states are NATIVE, ALT, DRAIN and GAP. A `target` register records the mode being switched to.
  - NATIVE: `ce_cpu_p/n` = `en`&`pn_p`/`pn_n`. If mode_alt==1, set target=ALT and go to DRAIN.
  - ALT: `ce_cpu_p/n` = `pa_p`/`pa_n`; `en` is forced 1. If mode_alt==0, set target=NATIVE and go to DRAIN.
  - DRAIN: keep generating strobes from the source state. Leave for GAP in the cycle after that source emits its n strobe, so a p/n pair is never split. In native, a stalled n (`en`=0) does not count as emitted. Load `gap_cnt`=GAP_PERIODS.
  - GAP: no CPU strobes. Decrement `gap_cnt` each time cnt_a==0. When `gap_cnt` reaches 0, go to `target`. If mode_alt no longer matches `target` at that moment, go to the state that matches mode_alt instead.
- `mode_alt` toggling during DRAIN or GAP does not abort the switch. The current switch always completes, and the final state is chosen by the value sampled at GAP exit.
- `ce_aux` = (cnt_x==0).
- `ce_ref_p/n` = `pn_p`/`pn_n` in every state, including during stalls and switches.

## Timing
- All outputs are registered. A strobe is high for exactly one `clk_sys` cycle, namely the cycle after the counter matches.
- `ce_cpu_p` and `ce_cpu_n` are never high in the same cycle. Two consecutive CPU strobes always alternate p, n, p, n across stalls and mode switches.
- Wait latency: `wait_req` is sampled only when cnt_n==0.
  - A request asserted in any other cycle takes effect at the next native period.
  - While `en`=0, whole native periods are suppressed, both p and n.
- Releasing `wait_req` resumes strobes at the next period boundary, with p first.
- Reset values: all counters 0, state NATIVE, `en`=1, `gap_cnt`=0. Every output is 0 while `reset` is high and in the cycle after release.
- Reset asserted mid-switch returns immediately to NATIVE; the pending `target` is discarded.
- Minimum switch duration is GAP_PERIODS×DIV_ALT cycles plus the drain time. `switching` is high for exactly that duration.

## Test plan
- Defaults, mode_alt=0, no wait, run 64 cycles. Expect `ce_cpu_p` and `ce_ref_p` at cycles 1, 17, 33, 49 after reset release. Expect `ce_cpu_n` at 9, 25, 41, 57. Expect `ce_aux` every 12 cycles.
- Hold `wait_req`=1 across two native periods. Expect no `ce_cpu_p/n` for those 32 cycles while `ce_ref_p/n` continue. The first CPU strobe after release is p.
- Same stall with `throttle_off`=1. Expect no strobes suppressed.
- Set mode_alt 0→1 mid-native period. Expect the pending n to be delivered, then `switching`=1 for the full gap (no CPU strobes). ALT then starts with p at cnt_a==0. Measure ALT p spacing as 27 cycles and p→n as 13 cycles.
- Toggle mode_alt 0→1→0 during GAP. Expect the switch to complete and return to NATIVE with `alt_active`=0. Check that the p/n alternation is unbroken.
- Assert `reset` during GAP. Expect all outputs 0 asynchronously and state NATIVE after release. The first `ce_cpu_p` is 1 cycle after release.

Source files
------------

// File: rtl/cpu_clk_gen_if.sv
// cpu_clk_gen_if: control and strobe bundle between the machine top level and
// the CPU clock-enable generator.
//   master : top-level mode/contention logic (drives requests, sees strobes)
//   slave  : cpu_clk_gen (receives requests, drives strobes and status)
// Requests : mode_alt, wait_req, throttle_off
// Strobes  : ce_ref_p, ce_ref_n, ce_cpu_p, ce_cpu_n, ce_aux
// Status   : alt_active, switching
interface cpu_clk_gen_if;
   logic mode_alt;
   logic wait_req;
   logic throttle_off;
   logic ce_ref_p;
   logic ce_ref_n;
   logic ce_cpu_p;
   logic ce_cpu_n;
   logic ce_aux;
   logic alt_active;
   logic switching;

   modport master (
      output mode_alt, wait_req, throttle_off,
      input  ce_ref_p, ce_ref_n, ce_cpu_p, ce_cpu_n, ce_aux, alt_active, switching
   );

   modport slave (
      input  mode_alt, wait_req, throttle_off,
      output ce_ref_p, ce_ref_n, ce_cpu_p, ce_cpu_n, ce_aux, alt_active, switching
   );
endinterface

// File: rtl/cpu_clk_gen.sv
// cpu_clk_gen: clock-enable generator for the machine core. Produces CPU
// p/n phase enables in native or alternate timing with a gapped, glitch-free
// hand-over between the two, native-rate reference strobes and an aux strobe.
// Ports:
//   clk_sys : system clock, all flops
//   reset   : asynchronous, active-high
//   bus     : cpu_clk_gen_if.slave (mode_alt/wait_req/throttle_off in,
//             ce_* strobes, alt_active, switching out; all outputs registered)
module cpu_clk_gen #(
   parameter int DIV_NATIVE  = 16,
   parameter int DIV_ALT     = 27,
   parameter int DIV_AUX     = 12,
   parameter int GAP_PERIODS = 3
) (
   input  logic         clk_sys,
   input  logic         reset,
   cpu_clk_gen_if.slave bus
);
   localparam int NW = $clog2(DIV_NATIVE);
   localparam int AW = $clog2(DIV_ALT);
   localparam int XW = $clog2(DIV_AUX);

   typedef enum logic [1:0] {S_NATIVE, S_ALT, S_DRAIN, S_GAP} state_t;

   logic [NW-1:0] cnt_n_q, cnt_n_d;
   logic [AW-1:0] cnt_a_q, cnt_a_d;
   logic [XW-1:0] cnt_x_q, cnt_x_d;
   state_t        state_q, state_d;
   logic          tgt_alt_q, tgt_alt_d;   // 1: switching towards ALT
   logic          en_q, en_d;
   logic [3:0]    gap_q, gap_d;
   logic          ph_q, ph_d;             // 1: last CPU strobe was p
   logic          pn_p, pn_n, pa_p, pa_n;
   logic          src_alt, raw_p, raw_n, cpu_p_d, cpu_n_d;
   logic          ref_p_q, ref_n_q, cpu_p_q, cpu_n_q, aux_q, alt_q, sw_q;

   always_comb begin
      cnt_n_d = (cnt_n_q == NW'(DIV_NATIVE - 1)) ? '0 : cnt_n_q + 1'b1;
      cnt_a_d = (cnt_a_q == AW'(DIV_ALT - 1))    ? '0 : cnt_a_q + 1'b1;
      cnt_x_d = (cnt_x_q == XW'(DIV_AUX - 1))    ? '0 : cnt_x_q + 1'b1;

      pn_p = (cnt_n_q == '0);
      pn_n = (cnt_n_q == NW'(DIV_NATIVE / 2));
      pa_p = (cnt_a_q == '0);
      pa_n = (cnt_a_q == AW'(DIV_ALT / 2));

      // Stall decision is taken once per native period and covers both its
      // p and n, so the freshly sampled value gates the p of this boundary.
      en_d = pn_p ? (~bus.wait_req | bus.throttle_off | (state_q == S_ALT)) : en_q;

      // Drain keeps the timing of the state being left.
      src_alt = (state_q == S_ALT) | ((state_q == S_DRAIN) & ~tgt_alt_q);
      raw_p   = src_alt ? pa_p : (en_d & pn_p);
      raw_n   = src_alt ? pa_n : (en_d & pn_n);

      // Phase tracking: a timing source entered mid-period may offer n first;
      // it is held back until a p has gone out, keeping p,n,p,n unbroken.
      cpu_p_d = (state_q != S_GAP) & raw_p & ~ph_q;
      cpu_n_d = (state_q != S_GAP) & raw_n &  ph_q;
      ph_d    = cpu_p_d ? 1'b1 : (cpu_n_d ? 1'b0 : ph_q);

      state_d   = state_q;
      tgt_alt_d = tgt_alt_q;
      gap_d     = gap_q;
      case (state_q)
         S_NATIVE: if (bus.mode_alt) begin
            tgt_alt_d = 1'b1;
            state_d   = S_DRAIN;
         end
         S_ALT: if (!bus.mode_alt) begin
            tgt_alt_d = 1'b0;
            state_d   = S_DRAIN;
         end
         S_DRAIN: if (cpu_n_d) begin
            state_d = S_GAP;
            gap_d   = 4'(GAP_PERIODS);
         end
         S_GAP: begin
            // Count down on alt boundaries, then leave on the last cycle of an
            // alt period so ALT resumes exactly at cnt_a==0. The gap therefore
            // always spans at least GAP_PERIODS whole alt periods. The mode
            // sampled here wins; when it still equals target this is target.
            if (pa_p && gap_q != 4'd0)
               gap_d = gap_q - 4'd1;
            else if (gap_q == 4'd0 && cnt_a_q == AW'(DIV_ALT - 1))
               state_d = bus.mode_alt ? S_ALT : S_NATIVE;
         end
         default: state_d = S_NATIVE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt_n_q   <= '0;
         cnt_a_q   <= '0;
         cnt_x_q   <= '0;
         state_q   <= S_NATIVE;
         tgt_alt_q <= 1'b0;
         en_q      <= 1'b1;
         gap_q     <= 4'd0;
         ph_q      <= 1'b0;
         ref_p_q   <= 1'b0;
         ref_n_q   <= 1'b0;
         cpu_p_q   <= 1'b0;
         cpu_n_q   <= 1'b0;
         aux_q     <= 1'b0;
         alt_q     <= 1'b0;
         sw_q      <= 1'b0;
      end else begin
         cnt_n_q   <= cnt_n_d;
         cnt_a_q   <= cnt_a_d;
         cnt_x_q   <= cnt_x_d;
         state_q   <= state_d;
         tgt_alt_q <= tgt_alt_d;
         en_q      <= en_d;
         gap_q     <= gap_d;
         ph_q      <= ph_d;
         ref_p_q   <= pn_p;
         ref_n_q   <= pn_n;
         cpu_p_q   <= cpu_p_d;
         cpu_n_q   <= cpu_n_d;
         aux_q     <= (cnt_x_q == '0);
         // Status flags follow the next state so they line up with state_q.
         alt_q     <= (state_d == S_ALT);
         sw_q      <= (state_d == S_DRAIN) | (state_d == S_GAP);
      end
   end

   assign bus.ce_ref_p   = ref_p_q;
   assign bus.ce_ref_n   = ref_n_q;
   assign bus.ce_cpu_p   = cpu_p_q;
   assign bus.ce_cpu_n   = cpu_n_q;
   assign bus.ce_aux     = aux_q;
   assign bus.alt_active = alt_q;
   assign bus.switching  = sw_q;
endmodule

// File: tb/tb_cpu_clk_gen.sv
// tb_cpu_clk_gen: directed bench for cpu_clk_gen with default parameters.
// Cycle k = the cycle after the k-th rising edge following reset release.
module tb_cpu_clk_gen;
   logic clk_sys = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic last_p = 1'b0;

   cpu_clk_gen_if bus();

   cpu_clk_gen #(
      .DIV_NATIVE(16), .DIV_ALT(27), .DIV_AUX(12), .GAP_PERIODS(3)
   ) dut (
      .clk_sys(clk_sys),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic wreq;
      logic thr;
      int   ncyc;
      int   cp, cn, rp, rn, ax;
   } seg_t;

   // {cpu_p, cpu_n, ref_p, ref_n, aux, alt_active, switching}
   function automatic int outs();
      return int'({bus.ce_cpu_p, bus.ce_cpu_n, bus.ce_ref_p, bus.ce_ref_n,
                   bus.ce_aux, bus.alt_active, bus.switching});
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock; sample at the falling edge; check p/n ordering on every strobe.
   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
      cyc++;
      if (bus.ce_cpu_p || bus.ce_cpu_n) begin
         chk("cpu_pn_overlap", int'(bus.ce_cpu_p & bus.ce_cpu_n), 0);
         chk("cpu_alternation", int'(bus.ce_cpu_p), int'(!last_p));
         last_p = bus.ce_cpu_p;
      end
   endtask

   // Step until a CPU n appears while switching (drain finished, now in GAP).
   task automatic wait_gap(input int bound, output int at);
      at = -1;
      for (int k = 0; k < bound; k++) begin
         step();
         if (bus.ce_cpu_n && bus.switching) begin
            at = cyc;
            break;
         end
      end
   endtask

   // Drive mode_alt=pval for steps [0,pend), then base; run to end of switch.
   task automatic gap_run(input logic base, input logic pval, input int pend,
                          output int fall, output int strb, output int altv);
      fall = -1; strb = 0; altv = -1;
      for (int k = 0; k < 300; k++) begin
         bus.mode_alt = (k < pend) ? pval : base;
         step();
         if (!bus.switching) begin
            fall = cyc;
            altv = int'(bus.alt_active);
            break;
         end
         strb += int'(bus.ce_cpu_p | bus.ce_cpu_n);
      end
   endtask

   task automatic next_strobe(input int bound, output int at, output int isp);
      at = -1; isp = -1;
      for (int k = 0; k < bound; k++) begin
         step();
         if (bus.ce_cpu_p || bus.ce_cpu_n) begin
            at  = cyc;
            isp = int'(bus.ce_cpu_p);
            break;
         end
      end
   endtask

   initial begin
      seg_t segs[8];
      int   cp, cn, rp, rn, ax;
      int   sw_rise, drain_n, sw_fall, alt_fall, gap_strb, at, isp, strb, altv;
      int   ap[$];
      int   an[$];
      logic [6:0] exp;

      segs[0] = '{1'b1, 1'b0, 32, 0, 0, 2, 2, 2};
      segs[1] = '{1'b0, 1'b0, 32, 2, 2, 2, 2, 3};
      segs[2] = '{1'b1, 1'b1, 32, 2, 2, 2, 2, 3};
      segs[3] = '{1'b0, 1'b0,  4, 1, 0, 1, 0, 0};
      segs[4] = '{1'b1, 1'b0, 12, 0, 1, 0, 1, 1};
      segs[5] = '{1'b0, 1'b0, 16, 1, 1, 1, 1, 1};
      segs[6] = '{1'b1, 1'b0, 16, 0, 0, 1, 1, 2};
      segs[7] = '{1'b0, 1'b0, 16, 1, 1, 1, 1, 1};

      bus.mode_alt = 1'b0; bus.wait_req = 1'b0; bus.throttle_off = 1'b0;
      reset = 1'b1;
      @(negedge clk_sys);
      chk("reset_hold", outs(), 0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0; cyc = 0; last_p = 1'b0;
      chk("reset_cycle0", outs(), 0);

      // Free-running native timing, cycles 1..64.
      for (int k = 1; k <= 64; k++) begin
         step();
         exp = {((k - 1) % 16 == 0), ((k - 1) % 16 == 8),
                ((k - 1) % 16 == 0), ((k - 1) % 16 == 8),
                ((k - 1) % 12 == 0), 1'b0, 1'b0};
         chk($sformatf("native_c%0d", k), outs(), int'(exp));
      end

      // Contention stalls, cycles 65..224; each segment starts at cycle 65+.
      for (int s = 0; s < 8; s++) begin
         bus.wait_req = segs[s].wreq;
         bus.throttle_off = segs[s].thr;
         cp = 0; cn = 0; rp = 0; rn = 0; ax = 0;
         for (int k = 0; k < segs[s].ncyc; k++) begin
            step();
            cp += int'(bus.ce_cpu_p); cn += int'(bus.ce_cpu_n);
            rp += int'(bus.ce_ref_p); rn += int'(bus.ce_ref_n);
            ax += int'(bus.ce_aux);
         end
         chk($sformatf("seg%0d_cpu_p", s), cp, segs[s].cp);
         chk($sformatf("seg%0d_cpu_n", s), cn, segs[s].cn);
         chk($sformatf("seg%0d_ref_p", s), rp, segs[s].rp);
         chk($sformatf("seg%0d_ref_n", s), rn, segs[s].rn);
         chk($sformatf("seg%0d_aux", s), ax, segs[s].ax);
      end
      bus.wait_req = 1'b0; bus.throttle_off = 1'b0;

      // Native -> ALT requested after the p of cycle 225.
      repeat (4) step();
      bus.mode_alt = 1'b1;
      sw_rise = -1; drain_n = -1; sw_fall = -1; alt_fall = -1; gap_strb = 0;
      while (cyc < 360) begin
         step();
         if (bus.switching && sw_rise < 0) sw_rise = cyc;
         if (bus.ce_cpu_n && drain_n < 0) drain_n = cyc;
         if (drain_n >= 0 && cyc > drain_n && bus.switching &&
             (bus.ce_cpu_p || bus.ce_cpu_n)) gap_strb++;
         if (sw_rise >= 0 && !bus.switching && sw_fall < 0) begin
            sw_fall = cyc;
            alt_fall = int'(bus.alt_active);
         end
         if (sw_fall >= 0 && bus.ce_cpu_p) ap.push_back(cyc);
         if (sw_fall >= 0 && bus.ce_cpu_n) an.push_back(cyc);
      end
      chk("sw_rise", sw_rise, 229);
      chk("drain_n", drain_n, 233);
      chk("sw_fall", sw_fall, 324);
      chk("alt_at_fall", alt_fall, 1);
      chk("gap_strobes", gap_strb, 0);
      chk("alt_p0", (ap.size() > 0) ? ap[0] : -1, 325);
      chk("alt_n0", (an.size() > 0) ? an[0] : -1, 338);
      chk("alt_p1", (ap.size() > 1) ? ap[1] : -1, 352);

      // ALT -> native with a 0->1->0 glitch on mode_alt inside the gap.
      bus.mode_alt = 1'b0;
      wait_gap(100, at);
      chk("A_drain_n", at, 365);
      gap_run(1'b0, 1'b1, 5, at, strb, altv);
      chk("A_sw_fall", at, 459);
      chk("A_gap_strobes", strb, 0);
      chk("A_alt_active", altv, 0);
      next_strobe(40, at, isp);
      chk("A_first_cyc", at, 465);
      chk("A_first_is_p", isp, 1);

      // Native -> ALT, mode_alt dropped mid-gap: must land back in native.
      bus.mode_alt = 1'b1;
      wait_gap(100, at);
      chk("B_drain_n", at, 473);
      gap_run(1'b0, 1'b1, 3, at, strb, altv);
      chk("B_sw_fall", at, 567);
      chk("B_gap_strobes", strb, 0);
      chk("B_alt_active", altv, 0);
      next_strobe(40, at, isp);
      chk("B_first_cyc", at, 577);
      chk("B_first_is_p", isp, 1);

      // Reset in the middle of a gap.
      bus.mode_alt = 1'b1;
      wait_gap(100, at);
      chk("C_drain_n", at, 585);
      repeat (10) step();
      chk("C_in_gap", outs(), 1);
      #2;
      bus.mode_alt = 1'b0;
      reset = 1'b1;
      #1;
      chk("C_async_clear", outs(), 0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0; cyc = 0; last_p = 1'b0;
      chk("C_rel_cycle0", outs(), 0);
      step();
      chk("C_rel_cycle1", outs(), 7'b1010100);
      repeat (8) step();
      chk("C_rel_cycle9", outs(), 7'b0101000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
